// File: rtl/fir_result_fifo.sv
// rtl/fir_result_fifo.sv - FIR result capture FIFO with valid/ready output and drop accounting
//
// Purpose:
//   Captures one FIR result per rising edge of dav, buffers it in a small
//   circular FIFO and presents the head through a first-word-fall-through
//   valid/ready port. Results arriving while the FIFO is full (and not being
//   drained in the same cycle) are dropped and counted.
//
// Ports:
//   clk            system clock, posedge
//   reset          asynchronous active-high reset
//   sum            signed FIR result, sampled on the rising edge of dav
//   dav            FIR data-available strobe
//   outData        head-of-FIFO result, 0 when outValid is low
//   outValid       outData holds a valid result
//   outReady       consumer accepts outData this cycle
//   count          stored entries, 0..Depth
//   full / empty   count==Depth / count==0
//   overflow       sticky flag, a result was dropped
//   dropCnt        saturating count of dropped results
//   clearOverflow  synchronous clear of overflow and dropCnt

module fir_result_fifo #(
  parameter int DataWidth = 8,
  parameter int Depth     = 8,
  parameter int PtrWidth  = 3,
  parameter int DropWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DataWidth-1:0] sum,
  input  logic                 dav,
  output logic [DataWidth-1:0] outData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [PtrWidth:0]    count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic [DropWidth-1:0] dropCnt,
  input  logic                 clearOverflow
);

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrWidth-1:0]  wrPtr;
  logic [PtrWidth-1:0]  rdPtr;
  logic [PtrWidth-1:0]  rdPtrNext;
  logic [PtrWidth:0]    countNext;
  logic [DataWidth-1:0] headNext;
  logic                 davPrev;
  logic                 push;
  logic                 pop;
  logic                 accept;
  logic                 drop;

  assign full   = (count == (PtrWidth+1)'(Depth));
  assign empty  = (count == '0);
  assign push   = dav & ~davPrev;
  assign pop    = outValid & outReady;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_comb begin
    countNext = count;
    if (accept && !pop) begin
      countNext = count + 1'b1;
    end else if (!accept && pop) begin
      countNext = count - 1'b1;
    end
  end

  assign rdPtrNext = pop ? rdPtr + PtrWidth'(1) : rdPtr;

  // The registered head must see a result written on this same edge: when
  // the write slot is the next head (push into empty, or push+pop with one
  // entry), bypass the array and take sum directly.
  always_comb begin
    headNext = '0;
    if (countNext != '0) begin
      if (accept && (wrPtr == rdPtrNext)) begin
        headNext = sum;
      end else begin
        headNext = mem[rdPtrNext];
      end
    end
  end

  // Storage has no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wrPtr] <= sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      davPrev  <= 1'b0;
      outValid <= 1'b0;
      outData  <= '0;
    end else begin
      davPrev  <= dav;
      if (accept) begin
        wrPtr <= wrPtr + PtrWidth'(1);
      end
      rdPtr    <= rdPtrNext;
      count    <= countNext;
      outValid <= (countNext != '0);
      outData  <= headNext;
    end
  end

  // A drop in the same cycle as clearOverflow wins, restarting the count at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      dropCnt  <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clearOverflow) begin
        dropCnt <= DropWidth'(1);
      end else if (dropCnt != '1) begin
        dropCnt <= dropCnt + DropWidth'(1);
      end
    end else if (clearOverflow) begin
      overflow <= 1'b0;
      dropCnt  <= '0;
    end
  end

endmodule
